// File: rtl/calc_operand_entry.sv
// ---------------------------------------------------------------------------
// calc_operand_entry
//   Keypad-side front end of the BCD calculator, directly upstream of the ALU.
//   It takes one key per key_valid strobe and builds two packed-BCD operands
//   digit by digit. It also latches the operator. On '=' it holds the operands
//   and the operator stable for the ALU and pulses calc_start. After a result,
//   pressing an operator key chains the ALU result in as the new first operand.
//
// Parameters
//   NDIG     maximum digits per operand (1..4); unused upper digits read 0
//   LZ_SKIP  1: a '0' key on an empty operand is swallowed (not a digit)
//
// Ports
//   clk          in   system clock, rising edge
//   clear_n      in   asynchronous active-low reset
//   key_valid    in   one-cycle strobe qualifying key_code
//   key_code     in   0-9 digit, A add, B sub, C equals, D clear-entry, E/F none
//   result_bcd   in   ALU result, sampled when chaining and shown in S_RESULT
//   bcd1         out  operand 1 (packed BCD)
//   bcd2         out  operand 2 (packed BCD)
//   op_selected  out  00 none, 01 add, 10 sub
//   calc_start   out  one-cycle pulse, ALU inputs stable
//   display_bcd  out  bcd1 / bcd2 / result_bcd depending on state
//   entry_ovf    out  one-cycle pulse when a digit is rejected (operand full)
//   state        out  00 S_OP1, 01 S_OP2_WAIT, 10 S_OP2, 11 S_RESULT
// ---------------------------------------------------------------------------
module calc_operand_entry #(
  parameter int NDIG    = 4,
  parameter bit LZ_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] result_bcd,
  output logic [15:0] bcd1,
  output logic [15:0] bcd2,
  output logic [1:0]  op_selected,
  output logic        calc_start,
  output logic [15:0] display_bcd,
  output logic        entry_ovf,
  output logic [1:0]  state
);

  localparam logic [1:0] S_OP1      = 2'b00;
  localparam logic [1:0] S_OP2_WAIT = 2'b01;
  localparam logic [1:0] S_OP2      = 2'b10;
  localparam logic [1:0] S_RESULT   = 2'b11;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hC;
  localparam logic [3:0] K_CE  = 4'hD;

  // Keeps only the NDIG low digits of an operand.
  localparam logic [15:0] DIG_MASK = 16'((32'd1 << (4 * NDIG)) - 32'd1);
  localparam logic [2:0]  NDIG_C   = 3'(NDIG);

  logic [1:0]  state_q, state_d;
  logic [15:0] bcd1_q, bcd1_d;
  logic [15:0] bcd2_q, bcd2_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic [2:0]  cnt2_q, cnt2_d;
  logic [1:0]  op_q, op_d;
  logic        start_q, start_d;
  logic        ovf_q, ovf_d;

  // Digit-entry decode for whichever operand is currently being typed.
  logic        is_digit;
  logic        is_op;
  logic [1:0]  op_key;
  logic [15:0] act_reg;
  logic [2:0]  act_cnt;
  logic        dig_full;
  logic        dig_skip;
  logic        dig_take;
  logic [15:0] dig_reg;
  logic [2:0]  dig_cnt;

  always_comb begin
    is_digit = (key_code <= 4'd9);
    is_op    = (key_code == K_ADD) || (key_code == K_SUB);
    op_key   = (key_code == K_ADD) ? OP_ADD : OP_SUB;

    if ((state_q == S_OP2) || (state_q == S_OP2_WAIT)) begin
      act_reg = bcd2_q;
      act_cnt = cnt2_q;
    end else begin
      act_reg = bcd1_q;
      act_cnt = cnt1_q;
    end

    dig_full = (act_cnt == NDIG_C);
    dig_skip = LZ_SKIP && (act_cnt == 3'd0) && (key_code == 4'd0);
    dig_take = !dig_full && !dig_skip;
    dig_reg  = {act_reg[11:0], key_code} & DIG_MASK;
    dig_cnt  = act_cnt + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    op_d    = op_q;
    start_d = 1'b0;
    ovf_d   = 1'b0;

    if (key_valid) begin
      case (state_q)
        S_OP1: begin
          if (is_digit) begin
            ovf_d = dig_full;
            if (dig_take) begin
              bcd1_d = dig_reg;
              cnt1_d = dig_cnt;
            end
          end else if (is_op) begin
            op_d    = op_key;
            bcd2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            state_d = S_OP2_WAIT;
          end else if (key_code == K_CE) begin
            bcd1_d = 16'h0000;
            cnt1_d = 3'd0;
          end
        end

        S_OP2_WAIT: begin
          if (is_digit) begin
            // Any digit commits to operand 2, even a swallowed leading zero,
            // so that "x + 0 =" can still be entered.
            ovf_d = dig_full;
            if (dig_take) begin
              bcd2_d = dig_reg;
              cnt2_d = dig_cnt;
            end
            state_d = S_OP2;
          end else if (is_op) begin
            op_d = op_key;
          end else if (key_code == K_CE) begin
            op_d    = OP_NONE;
            state_d = S_OP1;
          end
        end

        S_OP2: begin
          if (is_digit) begin
            ovf_d = dig_full;
            if (dig_take) begin
              bcd2_d = dig_reg;
              cnt2_d = dig_cnt;
            end
          end else if (key_code == K_EQ) begin
            start_d = 1'b1;
            state_d = S_RESULT;
          end else if (key_code == K_CE) begin
            bcd2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            state_d = S_OP2_WAIT;
          end
        end

        default: begin // S_RESULT
          if (is_digit) begin
            bcd1_d  = {12'h000, key_code} & DIG_MASK;
            cnt1_d  = (LZ_SKIP && (key_code == 4'd0)) ? 3'd0 : 3'd1;
            bcd2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            op_d    = OP_NONE;
            state_d = S_OP1;
          end else if (is_op) begin
            // Chained result is treated as a full operand: no digits may be appended.
            bcd1_d  = result_bcd & DIG_MASK;
            cnt1_d  = NDIG_C;
            bcd2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            op_d    = op_key;
            state_d = S_OP2_WAIT;
          end else if (key_code == K_EQ) begin
            start_d = 1'b1;
          end else if (key_code == K_CE) begin
            bcd1_d  = 16'h0000;
            bcd2_d  = 16'h0000;
            cnt1_d  = 3'd0;
            cnt2_d  = 3'd0;
            op_d    = OP_NONE;
            state_d = S_OP1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_OP1;
      bcd1_q  <= 16'h0000;
      bcd2_q  <= 16'h0000;
      cnt1_q  <= 3'd0;
      cnt2_q  <= 3'd0;
      op_q    <= OP_NONE;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      op_q    <= op_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OP2:    display_bcd = bcd2_q;
      S_RESULT: display_bcd = result_bcd;
      default:  display_bcd = bcd1_q;
    endcase
  end

  assign bcd1        = bcd1_q;
  assign bcd2        = bcd2_q;
  assign op_selected = op_q;
  assign calc_start  = start_q;
  assign entry_ovf   = ovf_q;
  assign state       = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
module tb_calc_operand_entry;

  localparam int NDIG = 4;
  localparam bit LZ   = 1'b1;

  logic        clk;
  logic        clear_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] result_bcd;
  logic [15:0] bcd1;
  logic [15:0] bcd2;
  logic [1:0]  op_selected;
  logic        calc_start;
  logic [15:0] display_bcd;
  logic        entry_ovf;
  logic [1:0]  state;

  calc_operand_entry #(.NDIG(NDIG), .LZ_SKIP(LZ)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .result_bcd  (result_bcd),
    .bcd1        (bcd1),
    .bcd2        (bcd2),
    .op_selected (op_selected),
    .calc_start  (calc_start),
    .display_bcd (display_bcd),
    .entry_ovf   (entry_ovf),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  bit cmp_en;

  // Model: operands held as decimal integers plus digit counts.
  int m_v1, m_v2, m_c1, m_c2, m_op, m_st;
  bit m_start, m_ovf;

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(logic [15:0] b);
    int r;
    int w;
    r = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      r = r + int'(b[i*4 +: 4]) * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_v1 = 0; m_v2 = 0; m_c1 = 0; m_c2 = 0;
    m_op = 0; m_st = 0; m_start = 0; m_ovf = 0;
  endtask

  task automatic enter_digit(int which, int d);
    int c;
    c = (which == 1) ? m_c1 : m_c2;
    if (c == NDIG) m_ovf = 1;
    else if (!(LZ && c == 0 && d == 0)) begin
      if (which == 1) begin m_v1 = m_v1 * 10 + d; m_c1++; end
      else begin m_v2 = m_v2 * 10 + d; m_c2++; end
    end
  endtask

  task automatic model_step(bit v, int k);
    int lim;
    lim = 1;
    for (int i = 0; i < NDIG; i++) lim = lim * 10;
    m_start = 0;
    m_ovf   = 0;
    if (!v) return;
    if (k <= 9) begin
      case (m_st)
        0: enter_digit(1, k);
        1: begin enter_digit(2, k); m_st = 2; end
        2: enter_digit(2, k);
        default: begin
          m_v1 = k; m_c1 = (LZ && k == 0) ? 0 : 1;
          m_v2 = 0; m_c2 = 0; m_op = 0; m_st = 0;
        end
      endcase
    end else if (k == 10 || k == 11) begin
      case (m_st)
        0: begin m_op = k - 9; m_v2 = 0; m_c2 = 0; m_st = 1; end
        1: m_op = k - 9;
        2: ;
        default: begin
          m_v1 = bcd2int(result_bcd) % lim; m_c1 = NDIG;
          m_v2 = 0; m_c2 = 0; m_op = k - 9; m_st = 1;
        end
      endcase
    end else if (k == 12) begin
      if (m_st == 2) begin m_start = 1; m_st = 3; end
      else if (m_st == 3) m_start = 1;
    end else if (k == 13) begin
      case (m_st)
        0: begin m_v1 = 0; m_c1 = 0; end
        1: begin m_op = 0; m_st = 0; end
        2: begin m_v2 = 0; m_c2 = 0; m_st = 1; end
        default: model_reset();
      endcase
    end
  endtask

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [15:0] exp_disp;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_disp = (m_st == 2) ? int2bcd(m_v2) :
                   (m_st == 3) ? result_bcd : int2bcd(m_v1);
        chk("bcd1",        bcd1,                 int2bcd(m_v1));
        chk("bcd2",        bcd2,                 int2bcd(m_v2));
        chk("op_selected", {14'h0, op_selected}, 16'(m_op));
        chk("calc_start",  {15'h0, calc_start},  16'(m_start));
        chk("entry_ovf",   {15'h0, entry_ovf},   16'(m_ovf));
        chk("state",       {14'h0, state},       16'(m_st));
        chk("display_bcd", display_bcd,          exp_disp);
      end
    end
  endtask

  // One clock cycle with the given key (v=0: idle); model follows the edge.
  task automatic tick(bit v, int k);
    key_valid = v;
    key_code  = 4'(k);
    @(posedge clk);
    #1;
    if (!clear_n) model_reset();
    else model_step(v, k);
    key_valid = 1'b0;
  endtask

  task automatic keys(input int seq[]);
    foreach (seq[i]) tick(1'b1, seq[i]);
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 0;
    clear_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; result_bcd = 16'h0000;
    model_reset();
    fork compare_loop(); join_none

    // Reset state, including a key pressed while held in reset
    cmp_en = 1;
    tick(0, 0);
    tick(1, 5);
    chk("rst_bcd1",  bcd1, 16'h0000);
    chk("rst_state", {14'h0, state}, 16'h0000);
    chk("rst_op",    {14'h0, op_selected}, 16'h0000);
    clear_n = 1'b1;
    tick(0, 0);

    // 12 + 34 =
    keys('{1, 2, 10, 3, 4, 12});
    chk("t1_bcd1",  bcd1, 16'h0012);
    chk("t1_bcd2",  bcd2, 16'h0034);
    chk("t1_op",    {14'h0, op_selected}, 16'h0001);
    chk("t1_start", {15'h0, calc_start}, 16'h0001);
    chk("t1_state", {14'h0, state}, 16'h0003);
    tick(0, 0);
    chk("t1_start_off", {15'h0, calc_start}, 16'h0000);

    // Repeat '=' in S_RESULT re-pulses
    tick(1, 12);
    chk("rep_start", {15'h0, calc_start}, 16'h0001);

    // 45 - 23 =, ALU gives 22
    tick(1, 13);
    result_bcd = 16'h0022;
    keys('{4, 5, 11, 2, 3, 12});
    tick(0, 0);
    chk("t2_op",   {14'h0, op_selected}, 16'h0002);
    chk("t2_disp", display_bcd, 16'h0022);

    // Overflow on fifth digit, then leading-zero skip
    tick(1, 13);
    keys('{1, 2, 3, 4});
    chk("ovf_4th", {15'h0, entry_ovf}, 16'h0000);
    tick(1, 5);
    chk("ovf_5th", {15'h0, entry_ovf}, 16'h0001);
    chk("ovf_bcd1", bcd1, 16'h1234);
    tick(0, 0);
    chk("ovf_clr", {15'h0, entry_ovf}, 16'h0000);
    keys('{13, 0, 0, 7});
    chk("lz_bcd1", bcd1, 16'h0007);

    // Chain: 12 + 34 =, result 46, then - 5 =
    result_bcd = 16'h0000;
    keys('{13, 1, 2, 10, 3, 4, 12});
    result_bcd = 16'h0046;
    tick(0, 0);
    keys('{11, 5, 12});
    chk("ch_bcd1",  bcd1, 16'h0046);
    chk("ch_bcd2",  bcd2, 16'h0005);
    chk("ch_op",    {14'h0, op_selected}, 16'h0002);
    chk("ch_start", {15'h0, calc_start}, 16'h0001);
    // Chained operand is full: digits in S_OP2 don't touch bcd1; E/F ignored
    keys('{14, 15});
    // New digit in S_RESULT starts a fresh calculation
    tick(1, 8);
    chk("new_bcd1",  bcd1, 16'h0008);
    chk("new_state", {14'h0, state}, 16'h0000);

    // Chained operand rejects appended digits
    result_bcd = 16'h0000;
    keys('{10, 1, 12});
    result_bcd = 16'h0099;
    keys('{10, 13, 3});
    chk("chf_bcd1", bcd1, 16'h0099);
    chk("chf_ovf",  {15'h0, entry_ovf}, 16'h0001);

    // Operator replace, clear-entry back to S_OP1, '=' ignored in S_OP1
    tick(1, 13);
    keys('{1, 10, 11});
    chk("rep_op", {14'h0, op_selected}, 16'h0002);
    tick(1, 13);
    chk("ce_op",    {14'h0, op_selected}, 16'h0000);
    chk("ce_state", {14'h0, state}, 16'h0000);
    chk("ce_bcd1",  bcd1, 16'h0001);
    tick(1, 12);
    chk("eq_op1", {15'h0, calc_start}, 16'h0000);

    // S_OP2: operator ignored, D back to wait with bcd2 cleared, D to S_OP1
    keys('{10, 6, 0, 11, 14, 13});
    chk("op2ce_bcd2",  bcd2, 16'h0000);
    chk("op2ce_state", {14'h0, state}, 16'h0001);
    keys('{9, 12});
    tick(0, 0);
    keys('{13, 10, 2, 13, 13, 13});
    tick(0, 0);

    // Asynchronous reset mid-entry
    keys('{1, 2, 10, 3});
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    chk("arst_bcd1",  bcd1, 16'h0000);
    chk("arst_bcd2",  bcd2, 16'h0000);
    chk("arst_op",    {14'h0, op_selected}, 16'h0000);
    chk("arst_state", {14'h0, state}, 16'h0000);
    chk("arst_disp",  display_bcd, 16'h0000);
    tick(0, 0);
    clear_n = 1'b1;
    keys('{7, 10, 8, 12});
    tick(0, 0);
    tick(0, 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
